// File: rtl/multicycle_pkg.sv
// Shared opcode constants, FSM state and opcode-class types for the multi-cycle controller.
package multicycle_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNC_W   = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_LI    = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b110010;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b110011;
  localparam logic [OPCODE_W-1:0] OP_LB    = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_SB    = 6'b000111;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b011111;
  localparam logic [OPCODE_W-1:0] OP_B     = 6'b111111;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000001;

  localparam logic [FUNC_W-1:0] ALU_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] ALU_AND = 4'd2;
  localparam logic [FUNC_W-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR,
    S_MEM, S_WB_MEM, S_JUMP, S_CMP, S_NOP, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_ITYPE, CL_MEM, CL_JUMP, CL_CMP, CL_UNDEF
  } op_class_t;

  typedef struct packed {
    op_class_t         cls;
    logic              is_byte;
    logic              is_store;
    logic              is_bne;
    logic [FUNC_W-1:0] imm_func;
  } op_info_t;

endpackage

// File: rtl/multicycle_opcode_decode.sv
// Combinational opcode classifier: class, byte/store/bne flags and I-type ALU function.
module multicycle_opcode_decode
  import multicycle_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_info_t            info
);

  always_comb begin
    info          = '0;
    info.cls      = CL_UNDEF;
    info.imm_func = ALU_ADD;
    case (opcode)
      OP_RTYPE:      info.cls = CL_RTYPE;
      OP_LI, OP_ADDI: info.cls = CL_ITYPE;
      OP_ANDI: begin
        info.cls      = CL_ITYPE;
        info.imm_func = ALU_AND;
      end
      OP_ORI: begin
        info.cls      = CL_ITYPE;
        info.imm_func = ALU_OR;
      end
      OP_LW:   info.cls = CL_MEM;
      OP_LB: begin
        info.cls     = CL_MEM;
        info.is_byte = 1'b1;
      end
      OP_SW: begin
        info.cls      = CL_MEM;
        info.is_store = 1'b1;
      end
      OP_SB: begin
        info.cls      = CL_MEM;
        info.is_byte  = 1'b1;
        info.is_store = 1'b1;
      end
      OP_B:    info.cls = CL_JUMP;
      OP_BEQ:  info.cls = CL_CMP;
      OP_BNE: begin
        info.cls    = CL_CMP;
        info.is_bne = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle datapath sequencer with retired-instruction counter.
// Optional: define ILLEGAL_TRAP_EN to halt on undefined opcodes and raise Illegal.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned ALU_FUNC_W = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [31:0]           Instr,
  input  logic                  Zero,
  input  logic                  Mem_Ack,
  output logic                  IR_LdEn,
  output logic                  AB_LdEn,
  output logic                  ALUOut_LdEn,
  output logic                  MDR_LdEn,
  output logic                  PC_Sel,
  output logic                  PC_LdEn,
  output logic                  RF_WrEn,
  output logic                  RF_WrData_sel,
  output logic                  RF_B_sel,
  output logic                  ALU_Bin_sel,
  output logic [ALU_FUNC_W-1:0] ALU_func,
  output logic                  Mem_Req,
  output logic                  Mem_WrEn,
  output logic                  Mem_Byte,
  output logic [CNT_W-1:0]      Instr_Cnt,
  output logic                  Illegal
);

  state_t           state, state_nxt;
  op_info_t         dec, op_q;
  logic [CNT_W-1:0] cnt;
  logic             unused_instr;

  // Only the opcode and R-type function fields steer control.
  assign unused_instr = ^Instr[25:4];

  multicycle_opcode_decode u_decode (
    .opcode (Instr[31:26]),
    .info   (dec)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_INIT;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= dec;
      if (PC_LdEn) cnt <= cnt + CNT_W'(1);
    end
  end

  assign Instr_Cnt = cnt;

  // Next-state and output decode; Mealy only on Zero (CMP) and Mem_Ack (MEM).
  always_comb begin
    state_nxt     = state;
    IR_LdEn       = 1'b0;
    AB_LdEn       = 1'b0;
    ALUOut_LdEn   = 1'b0;
    MDR_LdEn      = 1'b0;
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = '0;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    Mem_Byte      = 1'b0;
    Illegal       = 1'b0;
    case (state)
      S_INIT:  state_nxt = S_FETCH;
      S_FETCH: begin
        IR_LdEn   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        AB_LdEn  = 1'b1;
        RF_B_sel = (dec.cls inside {CL_ITYPE, CL_MEM, CL_CMP});
        case (dec.cls)
          CL_RTYPE, CL_ITYPE: state_nxt = S_EXEC;
          CL_MEM:             state_nxt = S_ADDR;
          CL_JUMP:            state_nxt = S_JUMP;
          CL_CMP:             state_nxt = S_CMP;
`ifdef ILLEGAL_TRAP_EN
          default:            state_nxt = S_HALT;
`else
          default:            state_nxt = S_NOP;
`endif
        endcase
      end
      S_EXEC: begin
        ALUOut_LdEn = 1'b1;
        if (op_q.cls == CL_ITYPE) begin
          ALU_func    = ALU_FUNC_W'(op_q.imm_func);
          ALU_Bin_sel = 1'b1;
          RF_B_sel    = 1'b1;
        end else begin
          ALU_func    = ALU_FUNC_W'(Instr[3:0]);
        end
        state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        PC_LdEn       = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_ADDR: begin
        ALU_func    = ALU_FUNC_W'(ALU_ADD);
        ALU_Bin_sel = 1'b1;
        RF_B_sel    = 1'b1;
        ALUOut_LdEn = 1'b1;
        state_nxt   = S_MEM;
      end
      S_MEM: begin
        Mem_Req  = 1'b1;
        Mem_Byte = op_q.is_byte;
        Mem_WrEn = op_q.is_store;
        if (Mem_Ack) begin
          if (op_q.is_store) begin
            PC_LdEn   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            MDR_LdEn  = 1'b1;
            state_nxt = S_WB_MEM;
          end
        end
      end
      S_WB_MEM: begin
        RF_WrEn   = 1'b1;
        PC_LdEn   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        PC_Sel    = 1'b1;
        PC_LdEn   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_CMP: begin
        RF_B_sel  = 1'b1;
        ALU_func  = ALU_FUNC_W'(ALU_SUB);
        PC_Sel    = op_q.is_bne ? ~Zero : Zero;
        PC_LdEn   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_NOP: begin
        PC_LdEn   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        Illegal   = 1'b1;
`endif
        state_nxt = S_HALT;
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: a per-instruction cycle-list model predicts every output each cycle.
module tb_multicycle_control;

  logic        Clk, Reset_n, Zero, Mem_Ack;
  logic [31:0] Instr;
  logic        IR_LdEn, AB_LdEn, ALUOut_LdEn, MDR_LdEn, PC_Sel, PC_LdEn;
  logic        RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_Req, Mem_WrEn, Mem_Byte, Illegal;
  logic [31:0] Instr_Cnt;

  multicycle_control #(.ALU_FUNC_W(4), .CNT_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
    .IR_LdEn(IR_LdEn), .AB_LdEn(AB_LdEn), .ALUOut_LdEn(ALUOut_LdEn), .MDR_LdEn(MDR_LdEn),
    .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
    .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn), .Mem_Byte(Mem_Byte),
    .Instr_Cnt(Instr_Cnt), .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic ir, ab, aluo, mdr, pcsel, pcld, rfwr, rfwd, rfb, binsel;
    logic [3:0] func;
    logic req, wr, byt, ill;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  zero;
    logic  ack;
  } step_t;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_JUMP = 4,
                 K_BEQ = 5, K_BNE = 6, K_UNDEF = 7;

  step_t       steps[$];
  logic        halted;
  logic [31:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  legal_ops[12] = '{6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011,
                                 6'b000011, 6'b001111, 6'b000111, 6'b011111,
                                 6'b111111, 6'b000000, 6'b000001};

  function automatic outs_t observe();
    outs_t o;
    o = '{ir: IR_LdEn, ab: AB_LdEn, aluo: ALUOut_LdEn, mdr: MDR_LdEn, pcsel: PC_Sel,
          pcld: PC_LdEn, rfwr: RF_WrEn, rfwd: RF_WrData_sel, rfb: RF_B_sel,
          binsel: ALU_Bin_sel, func: ALU_func, req: Mem_Req, wr: Mem_WrEn,
          byt: Mem_Byte, ill: Illegal};
    return o;
  endfunction

  task automatic check_outs(input string tag, input outs_t got, input outs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: outputs=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    checks++;
    assert (Instr_Cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s: Instr_Cnt=%0d expected=%0d", tag, Instr_Cnt, exp_cnt);
    end
  endtask

  function automatic void push(input outs_t o, input logic z, input logic a);
    step_t s;
    s.o = o; s.zero = z; s.ack = a;
    steps.push_back(s);
  endfunction

  // Expected cycle list for one instruction, FETCH through its last state.
  function automatic void build(input logic [31:0] ins, input int waits, input int zmode);
    int         kind;
    logic [3:0] fn;
    logic       byt_f, z, a;
    outs_t      o;
    fn = 4'd0; byt_f = 1'b0;
    case (ins[31:26])
      6'b100000:            kind = K_R;
      6'b111000, 6'b110000: kind = K_I;
      6'b110010: begin kind = K_I; fn = 4'd2; end
      6'b110011: begin kind = K_I; fn = 4'd3; end
      6'b001111:            kind = K_LOAD;
      6'b000011: begin kind = K_LOAD;  byt_f = 1'b1; end
      6'b011111:            kind = K_STORE;
      6'b000111: begin kind = K_STORE; byt_f = 1'b1; end
      6'b111111:            kind = K_JUMP;
      6'b000000:            kind = K_BEQ;
      6'b000001:            kind = K_BNE;
      default:              kind = K_UNDEF;
    endcase
    steps.delete();
    halted = 1'b0;
    o = '0; o.ir = 1'b1;
    push(o, 1'($urandom), 1'($urandom));
    o = '0; o.ab = 1'b1;
    o.rfb = (kind != K_R && kind != K_JUMP && kind != K_UNDEF);
    push(o, 1'($urandom), 1'($urandom));
    case (kind)
      K_R, K_I: begin
        o = '0; o.aluo = 1'b1;
        if (kind == K_R) o.func = ins[3:0];
        else begin o.func = fn; o.binsel = 1'b1; o.rfb = 1'b1; end
        push(o, 1'($urandom), 1'($urandom));
        o = '0; o.rfwr = 1'b1; o.rfwd = 1'b1; o.pcld = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
      end
      K_LOAD, K_STORE: begin
        o = '0; o.binsel = 1'b1; o.rfb = 1'b1; o.aluo = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
        for (int w = 0; w <= waits; w++) begin
          o = '0; o.req = 1'b1; o.byt = byt_f; o.wr = (kind == K_STORE);
          a = (w == waits);
          if (a && kind == K_STORE) o.pcld = 1'b1;
          if (a && kind == K_LOAD)  o.mdr  = 1'b1;
          push(o, 1'($urandom), a);
        end
        if (kind == K_LOAD) begin
          o = '0; o.rfwr = 1'b1; o.pcld = 1'b1;
          push(o, 1'($urandom), 1'($urandom));
        end
      end
      K_JUMP: begin
        o = '0; o.pcsel = 1'b1; o.pcld = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
      end
      K_BEQ, K_BNE: begin
        z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        o = '0; o.rfb = 1'b1; o.func = 4'd1; o.pcld = 1'b1;
        o.pcsel = (kind == K_BEQ) ? z : ~z;
        push(o, z, 1'($urandom));
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        halted = 1'b1;
        for (int h = 0; h < 20; h++) begin
          o = '0; o.ill = 1'b1;
          push(o, 1'($urandom), 1'($urandom));
        end
`else
        o = '0; o.pcld = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
`endif
      end
    endcase
  endfunction

  // Asynchronous reset mid-cycle, then one S_INIT cycle; returns on the edge into FETCH.
  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1;
    exp_cnt = '0;
    check_outs("reset_asserted", observe(), '0);
    check_cnt("reset_asserted_cnt");
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check_outs("init_state", observe(), '0);
    check_cnt("init_cnt");
    @(posedge Clk);
  endtask

  // Called just after the edge into FETCH; returns just after the edge into the next FETCH.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int waits,
                           input int zmode, input int abort_at);
    build(ins, waits, zmode);
    for (int i = 0; i < steps.size(); i++) begin
      if (i > 0) @(posedge Clk);
      #1;
      Instr   = ins;
      Zero    = steps[i].zero;
      Mem_Ack = steps[i].ack;
      @(negedge Clk);
      check_outs($sformatf("%s op=%b cyc%0d", tag, ins[31:26], i), observe(), steps[i].o);
      check_cnt($sformatf("%s cnt cyc%0d", tag, i));
      if (i == abort_at) begin
        do_reset();
        return;
      end
      if (steps[i].o.pcld) exp_cnt = exp_cnt + 32'd1;
    end
    if (halted) do_reset();
    else @(posedge Clk);
  endtask

  initial begin
    logic [31:0] ins;
    Reset_n = 1'b0; Instr = '0; Zero = 1'b0; Mem_Ack = 1'b0; exp_cnt = '0;
    @(negedge Clk);
    do_reset();

    run_instr("addi",  {6'b110000, 26'h0123456}, 0, -1, -1);
    run_instr("rtype", {6'b100000, 22'h2AAAAA, 4'd5}, 0, -1, -1);
    run_instr("lw_w3", {6'b001111, 26'h0000010}, 3, -1, -1);
    run_instr("sb_w0", {6'b000111, 26'h0000004}, 0, -1, -1);
    run_instr("beq_z1", {6'b000000, 26'h0000008}, 0, 1, -1);
    run_instr("bne_z1", {6'b000001, 26'h0000008}, 0, 1, -1);
    run_instr("bne_z0", {6'b000001, 26'h0000008}, 0, 0, -1);
    run_instr("b",     {6'b111111, 26'h3FFFFFF}, 0, -1, -1);
    run_instr("andi",  {6'b110010, 26'h00000FF}, 0, -1, -1);
    run_instr("ori",   {6'b110011, 26'h00000F0}, 0, -1, -1);
    run_instr("undef", {6'b101010, 26'h1555555}, 0, -1, -1);
    run_instr("lw_abort", {6'b001111, 26'h0000020}, 5, -1, 4);
    run_instr("after_reset", {6'b111000, 26'h0000001}, 0, -1, -1);

    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) ins[31:26] = legal_ops[$urandom_range(0, 11)];
      run_instr("rand", ins, int'($urandom_range(0, 4)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle FSM controller for the processor datapath; replaces the single-cycle decoder by sequencing one instruction over 3–5+ cycles through shared ALU, register file and memory.
- Drives IR, A/B, ALUOut and MDR load enables, the existing datapath selects, and a req/ack handshake to data memory.
- Sits between the instruction register output and the datapath mux/enable inputs.

Parameters:
- ALU_FUNC_W, 4, width of ALU_func.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Instr  in  32  current IR contents; stable from DECODE onward.
- Zero  in  1  ALU zero flag.
- Mem_Ack  in  1  data memory done; single-cycle pulse or level.
- IR_LdEn  out  1  load instruction register.
- AB_LdEn  out  1  load A/B/immediate registers.
- ALUOut_LdEn  out  1  load ALU output register.
- MDR_LdEn  out  1  load memory data register.
- PC_Sel  out  1  0 = PC+4, 1 = branch target.
- PC_LdEn  out  1  update PC.
- RF_WrEn  out  1  register file write.
- RF_WrData_sel  out  1  1 = ALUOut, 0 = MDR.
- RF_B_sel  out  1  1 = rd field as read address B.
- ALU_Bin_sel  out  1  1 = immediate.
- ALU_func  out  ALU_FUNC_W  ALU operation.
- Mem_Req  out  1  data memory access active.
- Mem_WrEn  out  1  store; valid only with Mem_Req.
- Mem_Byte  out  1  byte access (lb/sb).
- Instr_Cnt  out  CNT_W  retired instructions.
- Illegal  out  1  see Optional Feature.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous, active-low.
- Reset: state = S_INIT, Instr_Cnt = 0, all outputs 0. Reset asserted mid-instruction aborts it: no PC, RF or memory update after assertion.
- S_INIT: all outputs 0; next state FETCH.
- FETCH: IR_LdEn=1 → DECODE.
- DECODE: AB_LdEn=1, RF_B_sel=1 for I/mem/branch classes. Classify Instr[31:26]:
  - 100000 → EXEC
  - 111000, 110000, 110010, 110011 → EXEC
  - 001111, 000011, 011111, 000111 → ADDR
  - 111111 → JUMP
  - 000000, 000001 → CMP
  - anything else → NOP
- EXEC: ALUOut_LdEn=1 → WB_ALU.
  - R-type: ALU_func = Instr[3:0], ALU_Bin_sel=0.
  - li/addi: func 0; andi: func 2; ori: func 3. All with ALU_Bin_sel=1, RF_B_sel=1.
- WB_ALU: RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_Sel=0 → FETCH.
- ADDR: ALU_func=0, ALU_Bin_sel=1, RF_B_sel=1, ALUOut_LdEn=1 → MEM.
- MEM: Mem_Req=1; Mem_Byte=1 for lb/sb; Mem_WrEn=1 for stores. Stay while Mem_Ack=0; no timeout. When Mem_Ack=1:
  - store: PC_LdEn=1 → FETCH.
  - load: MDR_LdEn=1 → WB_MEM.
  - Mem_Ack outside MEM is ignored.
- WB_MEM: RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1 → FETCH.
- JUMP: PC_Sel=1, PC_LdEn=1 → FETCH.
- CMP: RF_B_sel=1, ALU_Bin_sel=0, ALU_func=1. PC_Sel = Zero for beq, !Zero for bne, sampled combinationally this cycle. PC_LdEn=1 → FETCH.
- NOP: PC_LdEn=1, PC_Sel=0 → FETCH.
- Outputs: decoded combinationally from registered state plus a registered opcode class. Mealy only on Zero (CMP) and Mem_Ack (MEM). All outputs are 0 in any state that does not assert them.
- Latency in cycles, FETCH through last state:
  - R/I-type: 4
  - b, beq, bne, NOP: 3
  - lw/lb: 5 + wait cycles
  - sw/sb: 4 + wait cycles
- Instr_Cnt: +1 on every cycle where PC_LdEn=1. Wraps modulo 2^CNT_W.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE → HALT. In HALT: Illegal=1, all other outputs 0, PC not updated, held until Reset_n.
- Undefined: undefined opcode → NOP, and Illegal is tied 0.

Decomposition:
- Package multicycle_pkg: opcode constants, state enum, opcode-class enum, ALU func constants (ADD=0, SUB=1, AND=2, OR=3).
- Sub-module multicycle_opcode_decode: combinational, Instr[31:26] → class, byte flag, store flag, I-type ALU func.
- FSM, counter and output decode live in multicycle_control.

Test Plan:
- Reset: Reset_n low mid-MEM, then released → all outputs 0 and Instr_Cnt=0 for one cycle (S_INIT), IR_LdEn=1 on the next cycle.
- addi then R-type (Instr[3:0]=4'd5): each takes 4 cycles; ALU_func 0 then 5 in EXEC; RF_WrEn asserted one cycle each; Instr_Cnt 0→2.
- lw with Mem_Ack delayed 3 cycles: Mem_Req high exactly 4 cycles, Mem_WrEn=0 throughout, MDR_LdEn on the ack cycle, RF_WrEn/RF_WrData_sel=0 the next cycle. sb with immediate ack: Mem_WrEn=Mem_Byte=1 for one cycle, then FETCH.
- beq with Zero=1 → PC_Sel=1; bne with Zero=1 → PC_Sel=0. Both take 3 cycles with PC_LdEn=1 in CMP.
- Opcode 6'b101010: without ILLEGAL_TRAP_EN → NOP, 3 cycles, Instr_Cnt +1. With it → Illegal=1 held, PC_LdEn=0 for 20 cycles, cleared only by Reset_n.
